// File: rtl/sa_os_ctrl_if.sv
// Tile-level bus of the output-stationary array sequencer: scheduler handshake,
// operand buffer read port and skewed array feed.
interface sa_os_ctrl_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int K_W   = 10
) ();
  logic                 start;
  logic [K_W-1:0]       k_len;
  logic                 busy;
  logic                 done;
  logic                 res_valid;
  logic                 a_rd_en;
  logic                 b_rd_en;
  logic [K_W-1:0]       rd_addr;
  logic [WIDTH*N-1:0]   a_rd_data;
  logic [WIDTH*N-1:0]   b_rd_data;
  logic [WIDTH*N-1:0]   arr_aa;
  logic [WIDTH*N-1:0]   arr_bb;
  logic                 arr_clr;

  // Scheduler / buffer / array side.
  modport master (
    output start, k_len, a_rd_data, b_rd_data,
    input  busy, done, res_valid, a_rd_en, b_rd_en, rd_addr,
           arr_aa, arr_bb, arr_clr
  );

  // Sequencer side.
  modport slave (
    input  start, k_len, a_rd_data, b_rd_data,
    output busy, done, res_valid, a_rd_en, b_rd_en, rd_addr,
           arr_aa, arr_bb, arr_clr
  );
endinterface

// File: rtl/sa_os_ctrl.sv
// Per-tile sequencer for the output-stationary systolic MAC array:
// clear, skewed operand feed, wavefront drain, results-final handshake.
module sa_os_ctrl #(
  parameter int N      = 8,
  parameter int WIDTH  = 8,
  parameter int K_W    = 10,
  parameter int PE_LAT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  sa_os_ctrl_if.slave  bus
);

  localparam int DR_LEN = 2 * N + PE_LAT;
  localparam int DR_W   = $clog2(DR_LEN + 1);
  localparam logic [DR_W-1:0] DR_LOAD = DR_W'(DR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [K_W-1:0]     k_reg;
  logic [K_W-1:0]     feed_cnt;
  logic [DR_W-1:0]    drn_cnt;
  logic               clr_q;
  logic               rv_q;
  logic               rd_en_d;
  logic               feed_last;
  logic               rd_en;
  logic [WIDTH*N-1:0] aa;
  logic [WIDTH*N-1:0] bb;

  // Compare against k_reg-1 so k_len = 2^K_W-1 ends without the counter wrapping.
  assign feed_last = (feed_cnt == k_reg - K_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.rd_addr = '0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = CLEAR;
      end
      CLEAR: begin
        bus.busy  = 1'b1;
        state_nxt = (k_reg == '0) ? DONE : FEED;
      end
      FEED: begin
        bus.busy    = 1'b1;
        rd_en       = 1'b1;
        bus.rd_addr = feed_cnt;
        if (feed_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (drn_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_reg    <= '0;
      feed_cnt <= '0;
      drn_cnt  <= '0;
      clr_q    <= 1'b0;
      rv_q     <= 1'b0;
      rd_en_d  <= 1'b0;
    end else begin
      // Clear is registered off the next state so it lines up with CLEAR.
      clr_q   <= (state_nxt == CLEAR);
      rd_en_d <= rd_en;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            k_reg <= bus.k_len;
            rv_q  <= 1'b0;
          end
        end
        CLEAR: feed_cnt <= '0;
        FEED: begin
          feed_cnt <= feed_cnt + K_W'(1);
          if (feed_last) drn_cnt <= DR_LOAD;
        end
        DRAIN: drn_cnt <= drn_cnt - DR_W'(1);
        DONE:  rv_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.a_rd_en   = rd_en;
  assign bus.b_rd_en   = rd_en;
  assign bus.arr_clr   = clr_q;
  assign bus.res_valid = rv_q;

  // Lane z gets z+1 stages; stage 0 zero-fills slots with no read in flight.
  for (genvar z = 0; z < N; z++) begin : g_lane
    logic [WIDTH-1:0] a_st [z+1];
    logic [WIDTH-1:0] b_st [z+1];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int unsigned i = 0; i < z + 1; i++) begin
          a_st[i] <= '0;
          b_st[i] <= '0;
        end
      end else begin
        a_st[0] <= rd_en_d ? bus.a_rd_data[z*WIDTH +: WIDTH] : '0;
        b_st[0] <= rd_en_d ? bus.b_rd_data[z*WIDTH +: WIDTH] : '0;
        for (int unsigned i = 1; i < z + 1; i++) begin
          a_st[i] <= a_st[i-1];
          b_st[i] <= b_st[i-1];
        end
      end
    end

    assign aa[z*WIDTH +: WIDTH] = a_st[z];
    assign bb[z*WIDTH +: WIDTH] = b_st[z];
  end

  assign bus.arr_aa = aa;
  assign bus.arr_bb = bb;

endmodule

// File: doc/sa_os_ctrl.md
# sa_os_ctrl

Sequencer for the output-stationary 2D systolic MAC array. Per tile:
- clears the array accumulators;
- streams K operand vectors from the A and B operand buffers into the array edges, applying the diagonal skew the array needs;
- waits for the wavefront to drain;
- signals that all N×N results on the array output bus are final.

It sits between the tile scheduler and the array's AA/BB/RST pins.

## Interface
- N, 8, array dimension (HPE = VPE = N)
- WIDTH, 8, operand width per lane
- K_W, 10, width of the reduction-length field
- PE_LAT, 1, PE cycles from operand arrival to updated accumulator
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  start-tile request, sampled in IDLE only
- k_len  in  K_W  reduction length, sampled with start
- busy  out  1  high from CLEAR through DONE inclusive
- done  out  1  one-cycle pulse, results final
- res_valid  out  1  set with done; cleared by next accepted start or reset
- a_rd_en  out  1  A buffer read strobe
- b_rd_en  out  1  B buffer read strobe, always equal to a_rd_en
- rd_addr  out  K_W  common read address (k index)
- a_rd_data  in  WIDTH*N  A column k, lane z = bits [(z+1)*WIDTH-1 : z*WIDTH]
- b_rd_data  in  WIDTH*N  B row k, same lane packing
- arr_aa  out  WIDTH*N  skewed A feed to the array
- arr_bb  out  WIDTH*N  skewed B feed to the array
- arr_clr  out  1  accumulator clear to the array RST, registered

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - With start=1: latch k_len into k_reg, clear res_valid, go to CLEAR.
  - start is ignored in every other state; there is no queuing.
- **CLEAR**
  - arr_clr=1 for exactly this cycle.
  - If k_reg==0, go to DONE; the array holds cleared results, all zero.
  - Otherwise go to FEED.
- **FEED**
  - Lasts exactly k_reg cycles.
  - In the t-th FEED cycle (t = 0..k_reg-1): a_rd_en=b_rd_en=1 and rd_addr=t.
- **DRAIN**
  - Lasts exactly 2N+PE_LAT cycles, counted by an internal down-counter.
  - Read strobes are 0.
- **DONE**
  - done=1 and res_valid←1 for one cycle, then go to IDLE.
- **Buffer read latency:** fixed at 1. Data for rd_addr=t is present on a_rd_data/b_rd_data in the cycle after the strobe.
- **Skew**
  - Lane z of A and of B passes through a z+1 stage register chain.
  - Stage 0 captures the read data when the strobe from the previous cycle was 1; otherwise it captures zero.
  - arr_aa/arr_bb lane z is the last stage of its chain.
  - Consequence: lane 0 carries word k two cycles after its strobe, and lane z carries it z cycles later than lane 0.
  - Invalid slots are always zero, so the array accumulates nothing outside a tile.
- **Arithmetic:** none in this block. The counters are K_W bits wide; the DRAIN counter is wide enough for 2N+PE_LAT.
- **k_len = 2^K_W−1:** legal. The FEED counter must not wrap early.

## Timing
- **Reset values (RST=1, asynchronous):**
  - state=IDLE;
  - busy, done, res_valid, a_rd_en, b_rd_en, arr_clr all 0;
  - rd_addr=0;
  - all skew stages 0, so arr_aa = arr_bb = 0.
- **Reset mid-tile:** immediate return to IDLE with the reset values above. The partial tile is discarded and done does not pulse.
- **Cycle map:** start sampled in cycle 0, F = first FEED cycle = 2.
  - Cycle 1: CLEAR, busy=1.
  - Cycles 2 .. 1+K: FEED.
  - Cycles 2+K .. 1+K+2N+PE_LAT: DRAIN.
  - Cycle 2+K+2N+PE_LAT: DONE.
  - busy falls the cycle after DONE.
- **Operand placement:**
  - Word k on arr_aa lane z is valid in cycle F+k+2+z, zero otherwise.
  - arr_bb follows the same rule.
- **Back-to-back tiles:** start held high restarts the next tile in the cycle after DONE; IDLE lasts one cycle.
- **res_valid:** remains 1 through IDLE until the next start is accepted.

## Test plan
- Reset during FEED, N=4, K=3 (RST asserted in cycle 3):
  - all outputs are 0 in the same cycle;
  - after release, start runs a clean tile with done in cycle 14.
- Nominal tile, N=4, WIDTH=8, PE_LAT=1, k_len=3, start in cycle 0:
  - arr_clr=1 in cycle 1;
  - rd_en=1 in cycles 2–4 with rd_addr 0, 1, 2;
  - done=1 in cycle 14; busy=1 in cycles 1–14.
- Skew check, same configuration, buffer returning A word k = {lane3..0} = {k+4, k+3, k+2, k+1}:
  - arr_aa lane 0 = 1, 2, 3 in cycles 4–6;
  - arr_aa lane 3 = 4, 5, 6 in cycles 7–9;
  - every other lane slot is 0.
- End-to-end, with the array attached and A = B = identity (k_len=4):
  - on done, Y equals the identity matrix;
  - Y_OUT[i][i] = 1 and all other Y_OUT words are 0.
- k_len=0:
  - sequence is CLEAR in cycle 1, DONE in cycle 2;
  - no rd_en pulses; res_valid=1 from cycle 3.
- start pulsed in cycles 5 and 9 during a tile:
  - both are ignored; exactly one done pulse.
- start held constantly high:
  - done pulses are spaced 3+K+2N+PE_LAT cycles apart.
